// File: rtl/dmem_ctrl_if.sv
// ============================================================================
// Module      : dmem_ctrl_if
// Description : Data-memory request/ready bus between the MEM-stage controller
//               (master) and the data memory (slave).
// Revision    : 1.0
// ============================================================================
`default_nettype none

interface dmem_ctrl_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_ready;
    logic [31:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        input  mem_ready, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        output mem_ready, mem_rdata
    );
endinterface

`default_nettype wire

// File: rtl/dmem_ctrl.sv
// ============================================================================
// Module      : dmem_ctrl
// Description : MEM-stage data-memory controller with byte lanes, variable
//               latency handshake, pipeline stall, fault and timeout flags.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module dmem_ctrl #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  wire logic        clk,
    input  wire logic        reset,
    input  wire logic        MemReadM,
    input  wire logic        MemWriteM,
    input  wire logic [2:0]  funct3M,
    input  wire logic [31:0] ALUResultM,
    input  wire logic [31:0] WriteDataM,
    dmem_ctrl_if.master      bus,
    output logic      [31:0] RD_data,
    output logic      [1:0]  byteAddrM,
    output logic             StallMem,
    output logic             faultM,
    output logic             buserrM
);

    localparam logic [CNT_W-1:0] c_cnt_one  = CNT_W'(1);
    localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            r_state, w_state_nxt;
    logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
    logic [31:0]       r_rdata, w_rdata_nxt;
    logic              r_buserr, w_buserr_nxt;

    logic              w_access, w_load_ok, w_store_ok, w_illegal, w_misaligned, w_good;
    logic              w_req, w_fault;
    logic [3:0]        w_be;
    logic [31:0]       w_wdata;

    // funct3[1:0] encodes size (00 byte, 01 half, 10 word); bit 2 is unsigned.
    always_comb begin
        w_access     = MemReadM | MemWriteM;
        w_load_ok    = (funct3M == 3'b000) || (funct3M == 3'b001) || (funct3M == 3'b010) ||
                       (funct3M == 3'b100) || (funct3M == 3'b101);
        w_store_ok   = (funct3M == 3'b000) || (funct3M == 3'b001) || (funct3M == 3'b010);
        w_illegal    = (MemReadM & MemWriteM) | (MemReadM & ~w_load_ok) | (MemWriteM & ~w_store_ok);
        w_misaligned = ((funct3M[1:0] == 2'b10) & (ALUResultM[1:0] != 2'b00)) |
                       ((funct3M[1:0] == 2'b01) & ALUResultM[0]);
        w_good       = w_access & ~w_illegal & ~w_misaligned;
    end

    always_comb begin
        w_be    = 4'b0000;
        w_wdata = 32'h0;
        case (funct3M[1:0])
            2'b00: begin
                w_be    = 4'b0001 << ALUResultM[1:0];
                w_wdata = {4{WriteDataM[7:0]}};
            end
            2'b01: begin
                w_be    = ALUResultM[1] ? 4'b1100 : 4'b0011;
                w_wdata = {2{WriteDataM[15:0]}};
            end
            2'b10: begin
                w_be    = 4'b1111;
                w_wdata = WriteDataM;
            end
            default: begin
                w_be    = 4'b0000;
                w_wdata = 32'h0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_rdata  <= 32'h0;
            r_buserr <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_rdata  <= w_rdata_nxt;
            r_buserr <= w_buserr_nxt;
        end
    end

    // Request fields stay combinational from the EX/MEM inputs; the pipeline
    // is frozen while StallMem is high, so they are stable through WAIT.
    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_rdata_nxt  = r_rdata;
        w_buserr_nxt = r_buserr;
        w_req        = 1'b0;
        w_fault      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_good) begin
                    w_req = 1'b1;
                    if (bus.mem_ready) begin
                        if (MemReadM) w_rdata_nxt = bus.mem_rdata;
                        w_state_nxt = S_DONE;
                    end else begin
                        w_cnt_nxt   = c_cnt_one;
                        w_state_nxt = S_WAIT;
                    end
                end else if (w_access) begin
                    w_fault = 1'b1;
                end
            end
            S_WAIT: begin
                w_req = 1'b1;
                if (bus.mem_ready) begin
                    if (MemReadM) w_rdata_nxt = bus.mem_rdata;
                    w_state_nxt = S_DONE;
                end else if (r_cnt == c_cnt_last) begin
                    w_rdata_nxt  = 32'h0;
                    w_buserr_nxt = 1'b1;
                    w_state_nxt  = S_DONE;
                end else begin
                    w_cnt_nxt = r_cnt + c_cnt_one;
                end
            end
            S_DONE: begin
                w_buserr_nxt = 1'b0;
                w_cnt_nxt    = '0;
                w_state_nxt  = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Reset gates outputs combinationally so an in-flight request drops at once.
    always_comb begin
        bus.mem_req   = reset & w_req;
        bus.mem_we    = reset & w_req & MemWriteM;
        bus.mem_addr  = {ALUResultM[31:2], 2'b00};
        bus.mem_be    = (reset & w_req & MemWriteM) ? w_be    : 4'b0000;
        bus.mem_wdata = (reset & w_req & MemWriteM) ? w_wdata : 32'h0;
        StallMem      = reset & w_req;
        faultM        = reset & w_fault;
        buserrM       = reset & (r_state == S_DONE) & r_buserr;
        RD_data       = reset ? r_rdata : 32'h0;
        byteAddrM     = ALUResultM[1:0];
    end

endmodule

`default_nettype wire
